sha256_nonce_sequencer: RTL and testbench

- Upstream feeder for the 64-stage SHA-256 block processor.
- Accepts a mining job: a 256-bit midstate, the 96-bit header tail, and an inclusive nonce range.
- Builds one padded second-chunk block per nonce and issues it to the core under the core's ready/start handshake.
- Tags every issued block with its nonce, re-pairs each returned digest with that nonce, and forwards the pair downstream as a result pulse.

---
 rtl/sha256_nonce_sequencer_if.sv | 37 +++
 rtl/sha256_nonce_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_sha256_nonce_sequencer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_nonce_sequencer_if.sv
// Bundle of job, core and result signals for the SHA-256 nonce sequencer.
// slave = sequencer side, master = environment (job source, core, result sink).
interface sha256_nonce_sequencer_if;
  logic         job_valid;
  logic         job_ready;
  logic [255:0] job_midstate;
  logic [95:0]  job_tail;
  logic [31:0]  job_nonce_start;
  logic [31:0]  job_nonce_end;
  logic         abort;
  logic         core_start;
  logic         core_ready;
  logic [255:0] core_iv;
  logic [511:0] core_block;
  logic [255:0] core_digest;
  logic         core_digest_valid;
  logic         res_valid;
  logic [31:0]  res_nonce;
  logic [255:0] res_digest;
  logic         done;
  logic         done_aborted;
  logic         tag_err;

  modport slave (
    input  job_valid, job_midstate, job_tail, job_nonce_start, job_nonce_end, abort,
    input  core_ready, core_digest, core_digest_valid,
    output job_ready, core_start, core_iv, core_block,
    output res_valid, res_nonce, res_digest, done, done_aborted, tag_err
  );

  modport master (
    output job_valid, job_midstate, job_tail, job_nonce_start, job_nonce_end, abort,
    output core_ready, core_digest, core_digest_valid,
    input  job_ready, core_start, core_iv, core_block,
    input  res_valid, res_nonce, res_digest, done, done_aborted, tag_err
  );
endinterface

// File: rtl/sha256_nonce_sequencer.sv
// Feeds padded second-chunk blocks for a nonce range to a SHA-256 core and
// re-pairs each in-order digest with its nonce through a tag FIFO.
module sha256_nonce_sequencer #(
  parameter int TAG_DEPTH = 128,
  parameter int TAG_AW    = 7
) (
  input  logic                     clk,
  input  logic                     rst_n,
  sha256_nonce_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [TAG_AW:0] FULL_CNT = (TAG_AW + 1)'(TAG_DEPTH);

  state_t             state_q, state_d;
  logic [255:0]       midstate_q, midstate_d;
  logic [95:0]        tail_q, tail_d;
  logic [31:0]        nonce_cur_q, nonce_cur_d;
  logic [31:0]        nonce_end_q, nonce_end_d;
  logic               loaded_q, loaded_d;
  logic               aborted_q, aborted_d;
  logic [TAG_AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [TAG_AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [TAG_AW:0]    count_q, count_d;
  logic               res_valid_q, res_valid_d;
  logic [31:0]        res_nonce_q, res_nonce_d;
  logic [255:0]       res_digest_q, res_digest_d;
  logic               done_q, done_d;
  logic               done_aborted_q, done_aborted_d;
  logic               tag_err_q, tag_err_d;
  logic [31:0]        tag_mem_q [TAG_DEPTH];

  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;

  // Second chunk of an 80-byte header: tail, nonce, pad bit, zeros, 640-bit length.
  function automatic logic [511:0] build_block(input logic [95:0] tail, input logic [31:0] nonce);
    build_block = {tail, nonce, 32'h8000_0000, 288'd0, 32'h0000_0000, 32'h0000_0280};
  endfunction

  // Next-state, FIFO bookkeeping and result capture.
  always_comb begin
    state_d        = state_q;
    midstate_d     = midstate_q;
    tail_d         = tail_q;
    nonce_cur_d    = nonce_cur_q;
    nonce_end_d    = nonce_end_q;
    loaded_d       = loaded_q;
    aborted_d      = aborted_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    res_valid_d    = 1'b0;
    res_nonce_d    = res_nonce_q;
    res_digest_d   = res_digest_q;
    done_d         = 1'b0;
    done_aborted_d = 1'b0;
    tag_err_d      = tag_err_q;

    fifo_full  = (count_q == FULL_CNT);
    fifo_empty = (count_q == {(TAG_AW + 1){1'b0}});
    // abort masks the handshake so an aborting cycle never issues
    push = (state_q == ST_RUN) & bus.core_ready & ~fifo_full & ~bus.abort;
    pop  = bus.core_digest_valid & ~fifo_empty;

    if (push) begin
      nonce_cur_d = nonce_cur_q + 32'd1;
      wr_ptr_d    = wr_ptr_q + TAG_AW'(1);
    end else begin
      nonce_cur_d = nonce_cur_q;
    end

    if (pop) begin
      rd_ptr_d     = rd_ptr_q + TAG_AW'(1);
      res_valid_d  = 1'b1;
      res_nonce_d  = tag_mem_q[rd_ptr_q];
      res_digest_d = bus.core_digest;
    end else if (bus.core_digest_valid) begin
      tag_err_d = 1'b1;
    end else begin
      res_valid_d = 1'b0;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + (TAG_AW + 1)'(1);
      2'b01:   count_d = count_q - (TAG_AW + 1)'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (bus.job_valid) begin
          midstate_d  = bus.job_midstate;
          tail_d      = bus.job_tail;
          nonce_cur_d = bus.job_nonce_start;
          nonce_end_d = bus.job_nonce_end;
          loaded_d    = 1'b1;
          aborted_d   = 1'b0;
          state_d     = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (bus.abort) begin
          aborted_d = 1'b1;
          state_d   = ST_DRAIN;
        end else if (push && (nonce_cur_q == nonce_end_q)) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (fifo_empty && !bus.core_digest_valid) begin
          done_d         = 1'b1;
          done_aborted_d = aborted_q;
          state_d        = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, job and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      midstate_q     <= 256'd0;
      tail_q         <= 96'd0;
      nonce_cur_q    <= 32'd0;
      nonce_end_q    <= 32'd0;
      loaded_q       <= 1'b0;
      aborted_q      <= 1'b0;
      wr_ptr_q       <= {TAG_AW{1'b0}};
      rd_ptr_q       <= {TAG_AW{1'b0}};
      count_q        <= {(TAG_AW + 1){1'b0}};
      res_valid_q    <= 1'b0;
      res_nonce_q    <= 32'd0;
      res_digest_q   <= 256'd0;
      done_q         <= 1'b0;
      done_aborted_q <= 1'b0;
      tag_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      midstate_q     <= midstate_d;
      tail_q         <= tail_d;
      nonce_cur_q    <= nonce_cur_d;
      nonce_end_q    <= nonce_end_d;
      loaded_q       <= loaded_d;
      aborted_q      <= aborted_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      res_valid_q    <= res_valid_d;
      res_nonce_q    <= res_nonce_d;
      res_digest_q   <= res_digest_d;
      done_q         <= done_d;
      done_aborted_q <= done_aborted_d;
      tag_err_q      <= tag_err_d;
    end
  end

  // Tag storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem_q[wr_ptr_q] <= nonce_cur_q;
    end
  end

  assign bus.job_ready    = (state_q == ST_IDLE);
  assign bus.core_start   = push;
  assign bus.core_iv      = midstate_q;
  assign bus.core_block   = loaded_q ? build_block(tail_q, nonce_cur_q) : 512'd0;
  assign bus.res_valid    = res_valid_q;
  assign bus.res_nonce    = res_nonce_q;
  assign bus.res_digest   = res_digest_q;
  assign bus.done         = done_q;
  assign bus.done_aborted = done_aborted_q;
  assign bus.tag_err      = tag_err_q;

endmodule

// File: tb/tb_sha256_nonce_sequencer.sv
// Bench for sha256_nonce_sequencer: a fixed-latency model core plus a nonce/digest
// scoreboard, driven from a table of jobs and a few hand-written corner sequences.
`timescale 1ns/1ps
module tb_sha256_nonce_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sha256_nonce_sequencer_if bus();

  sha256_nonce_sequencer #(.TAG_DEPTH(128), .TAG_AW(7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string        name;
    logic [255:0] ms;
    logic [95:0]  tail;
    logic [31:0]  start;
    logic [31:0]  stop;
    int           nexp;
    int           mode;        // 0: always ready, 1: ready one cycle in 66
    int           abort_after; // raise abort once this many handshakes happened (0: never)
    int           exp_peak;
    logic         exp_aborted;
  } vec_t;

  typedef struct {
    int           due;
    logic [255:0] dig;
  } pipe_t;

  localparam int CORE_LAT = 66; // digest strobe this many cycles after the start cycle

  pipe_t        pipe_q[$];
  logic [31:0]  exp_q[$];
  vec_t         vecs[5];
  int           n_chk, n_pass, cyc;
  int           outstanding, peak;
  int           hs_job, res_job, done_cnt, done_cyc, last_res_cyc;
  logic         done_ab_seen;
  int           mode, abort_after;
  bit           abort_used, inject_dv;
  logic [255:0] cur_ms;
  logic [95:0]  cur_tail;
  logic [31:0]  job_start;

  function automatic logic [511:0] exp_block(input logic [95:0] t, input logic [31:0] n);
    logic [511:0] b;
    b = '0;
    b[511:416] = t;
    b[415:384] = n;
    b[383:352] = 32'h8000_0000;
    b[31:0]    = 32'h0000_0280;
    return b;
  endfunction

  // Stand-in for the compression function: any fixed nonce-sensitive mix will do.
  function automatic logic [255:0] mix(input logic [255:0] iv, input logic [511:0] blk);
    logic [31:0] k;
    k = blk[415:384] * 32'h9E37_79B9;
    return iv ^ blk[511:256] ^ blk[255:0] ^ {8{k}};
  endfunction

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // One clock cycle: drive core inputs, note the handshake, then observe registered outputs.
  task automatic tick();
    pipe_t p;
    logic [31:0] n;
    bus.core_ready = (mode == 0) ? 1'b1 : ((cyc % 66) == 0);
    bus.abort = 1'b0;
    if (abort_after > 0 && !abort_used && hs_job == abort_after) begin
      bus.abort = 1'b1;
      abort_used = 1'b1;
    end
    bus.core_digest_valid = inject_dv;
    if (inject_dv) bus.core_digest = 256'hDEAD_BEEF;
    if (pipe_q.size() > 0 && pipe_q[0].due == cyc) begin
      bus.core_digest_valid = 1'b1;
      bus.core_digest = pipe_q[0].dig;
      void'(pipe_q.pop_front());
    end
    #1;
    if (bus.core_start === 1'b1) begin
      chk("core_block", bus.core_block, exp_block(cur_tail, job_start + 32'(hs_job)));
      chk("core_iv", {256'd0, bus.core_iv}, {256'd0, cur_ms});
      p.due = cyc + CORE_LAT;
      p.dig = mix(bus.core_iv, bus.core_block);
      pipe_q.push_back(p);
      hs_job++;
      outstanding++;
    end
    if (bus.core_digest_valid === 1'b1 && outstanding > 0) outstanding--;
    if (outstanding > peak) peak = outstanding;
    @(posedge clk);
    #1;
    if (bus.res_valid === 1'b1) begin
      res_job++;
      last_res_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL res_unexpected: got nonce %0h, expected no result", bus.res_nonce);
      end else begin
        n = exp_q.pop_front();
        chk("res_nonce", {480'd0, bus.res_nonce}, {480'd0, n});
        chk("res_digest", {256'd0, bus.res_digest}, {256'd0, mix(cur_ms, exp_block(cur_tail, n))});
      end
    end
    if (bus.done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      done_ab_seen = bus.done_aborted;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic start_job(input vec_t v);
    for (int i = 0; i < v.nexp; i++) exp_q.push_back(v.start + 32'(i));
    cur_ms = v.ms; cur_tail = v.tail; job_start = v.start;
    mode = v.mode; abort_after = v.abort_after; abort_used = 1'b0;
    hs_job = 0; res_job = 0; done_cnt = 0; peak = outstanding;
    done_cyc = -1; last_res_cyc = -1;
    chk({v.name, ":job_ready_idle"}, {511'd0, bus.job_ready}, 512'd1);
    bus.job_valid = 1'b1;
    bus.job_midstate = v.ms;
    bus.job_tail = v.tail;
    bus.job_nonce_start = v.start;
    bus.job_nonce_end = v.stop;
    tick();
    bus.job_valid = 1'b0;
    chk({v.name, ":job_ready_busy"}, {511'd0, bus.job_ready}, 512'd0);
  endtask

  task automatic run_job(input vec_t v);
    int n;
    start_job(v);
    n = 0;
    while (done_cnt == 0 && n < 3000) begin
      tick();
      n++;
    end
    if (done_cnt == 0) begin
      n_chk++;
      $display("FAIL %s:timeout: got no done after %0d cycles, expected done", v.name, n);
    end
    repeat (4) tick();
    chk({v.name, ":issued"}, 512'(hs_job), 512'(v.nexp));
    chk({v.name, ":results"}, 512'(res_job), 512'(v.nexp));
    chk({v.name, ":done_count"}, 512'(done_cnt), 512'd1);
    chk({v.name, ":done_aborted"}, {511'd0, done_ab_seen}, {511'd0, v.exp_aborted});
    chk({v.name, ":done_after_res"}, 512'(done_cyc - last_res_cyc), 512'd1);
    chk({v.name, ":fifo_peak"}, 512'(peak), 512'(v.exp_peak));
    chk({v.name, ":left_over"}, 512'(exp_q.size()), 512'd0);
    exp_q.delete();
  endtask

  initial begin
    vecs[0] = '{"single", {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                           32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19},
                96'd0, 32'h5, 32'h5, 1, 0, 0, 1, 1'b0};
    vecs[1] = '{"slow_core", {8{32'h0123_4567}}, 96'hA1A2A3A4_B1B2B3B4_C1C2C3C4,
                32'h10, 32'h13, 4, 1, 0, 1, 1'b0};
    vecs[2] = '{"wrap", {8{32'h89AB_CDEF}}, 96'h11111111_22222222_33333333,
                32'hFFFF_FFFE, 32'h0000_0001, 4, 0, 0, 4, 1'b0};
    vecs[3] = '{"full_rate", {4{64'hFEDC_BA98_7654_3210}}, 96'h0F0F0F0F_5A5A5A5A_17031E2B,
                32'h0, 32'd199, 200, 0, 0, 66, 1'b0};
    vecs[4] = '{"abort", {8{32'h5555_AAAA}}, 96'hCAFEF00D_12345678_9ABCDEF0,
                32'h100, 32'h103, 2, 0, 2, 2, 1'b1};

    n_chk = 0; n_pass = 0; cyc = 0; outstanding = 0; peak = 0;
    mode = 0; abort_after = 0; abort_used = 1'b0; inject_dv = 1'b0;
    hs_job = 0; res_job = 0; done_cnt = 0; job_start = 32'd0;
    cur_ms = '0; cur_tail = '0;
    rst_n = 1'b0;
    bus.job_valid = 1'b0; bus.job_midstate = '0; bus.job_tail = '0;
    bus.job_nonce_start = '0; bus.job_nonce_end = '0; bus.abort = 1'b0;
    bus.core_ready = 1'b0; bus.core_digest = '0; bus.core_digest_valid = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst:job_ready", {511'd0, bus.job_ready}, 512'd1);
    chk("rst:core_start", {511'd0, bus.core_start}, 512'd0);
    chk("rst:core_iv", {256'd0, bus.core_iv}, 512'd0);
    chk("rst:core_block", bus.core_block, 512'd0);
    chk("rst:res_valid", {511'd0, bus.res_valid}, 512'd0);
    chk("rst:done", {510'd0, bus.done, bus.done_aborted}, 512'd0);
    chk("rst:tag_err", {511'd0, bus.tag_err}, 512'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) run_job(vecs[i]);

    // Digest with nothing in flight: flagged and dropped.
    inject_dv = 1'b1;
    tick();
    inject_dv = 1'b0;
    chk("tagerr:set", {511'd0, bus.tag_err}, 512'd1);
    chk("tagerr:no_res", {511'd0, bus.res_valid}, 512'd0);
    tick();
    chk("tagerr:sticky", {511'd0, bus.tag_err}, 512'd1);
    chk("tagerr:no_res2", {511'd0, bus.res_valid}, 512'd0);

    // Reset in the middle of a running job.
    start_job('{"midrst", {8{32'h3141_5926}}, 96'h27182818_28459045_23536028,
                32'h200, 32'h2FF, 0, 0, 0, 0, 1'b0});
    repeat (10) tick();
    chk("midrst:issued", 512'(hs_job), 512'd10);
    rst_n = 1'b0;
    #1;
    chk("midrst:job_ready", {511'd0, bus.job_ready}, 512'd1);
    chk("midrst:core_start", {511'd0, bus.core_start}, 512'd0);
    chk("midrst:core_iv", {256'd0, bus.core_iv}, 512'd0);
    chk("midrst:core_block", bus.core_block, 512'd0);
    chk("midrst:tag_err", {511'd0, bus.tag_err}, 512'd0);
    chk("midrst:res_done", {509'd0, bus.res_valid, bus.done, bus.done_aborted}, 512'd0);
    pipe_q.delete();
    exp_q.delete();
    outstanding = 0;
    hs_job = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("postrst:job_ready", {511'd0, bus.job_ready}, 512'd1);
    chk("postrst:core_start", {511'd0, bus.core_start}, 512'd0);
    chk("postrst:core_block", bus.core_block, 512'd0);
    chk("postrst:no_issue", 512'(hs_job), 512'd0);

    run_job(vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
